// File: rtl/spi_fsm_if.sv
// Signal bundle between the SPI input conditioners / datapath and the
// transaction controller. cs is active-low; sclk_pos is a one-clk pulse per
// SCLK rise. The datapath strobes are single-clk pulses with no handshake:
// the receiving block acts on them in the clk they are high.
interface spi_fsm_if;
  logic cs;
  logic sclk_pos;
  logic rw_bit;
  logic addr_we;
  logic sr_we;
  logic dm_we;
  logic miso_buff;
  logic busy;

  modport master (
    output cs, sclk_pos, rw_bit,
    input  addr_we, sr_we, dm_we, miso_buff, busy
  );

  modport slave (
    input  cs, sclk_pos, rw_bit,
    output addr_we, sr_we, dm_we, miso_buff, busy
  );
endinterface

// File: rtl/spi_fsm.sv
// SPI memory transaction controller: address byte, then one read or write
// data byte. All outputs are decoded from the registered state only.
module spi_fsm #(
  parameter int BYTE_BITS = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  spi_fsm_if.slave         bus,
  output logic [2:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_ADDR     = 3'd1,
    GOT_ADDR     = 3'd2,
    READ_LOAD    = 3'd3,
    READ_SEND    = 3'd4,
    WRITE_GET    = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(BYTE_BITS);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             addr_we, sr_we, dm_we, miso_buff, busy;

  // State and bit-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state and counter. cs high aborts from anywhere and wins over
  // everything else, so a partially received write never reaches commit.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (bus.cs) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nx   = '0;
          state_nx = GET_ADDR;
        end
        GET_ADDR: begin
          if (cnt == FULL)        state_nx = GOT_ADDR;
          else if (bus.sclk_pos)  cnt_nx   = cnt + 1'b1;
        end
        GOT_ADDR: begin
          cnt_nx   = '0;
          state_nx = bus.rw_bit ? READ_LOAD : WRITE_GET;
        end
        READ_LOAD: state_nx = READ_SEND;
        READ_SEND: begin
          if (cnt == FULL)        state_nx = DONE;
          else if (bus.sclk_pos)  cnt_nx   = cnt + 1'b1;
        end
        WRITE_GET: begin
          if (cnt == FULL)        state_nx = WRITE_COMMIT;
          else if (bus.sclk_pos)  cnt_nx   = cnt + 1'b1;
        end
        WRITE_COMMIT: state_nx = DONE;
        DONE:         state_nx = DONE;
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    addr_we   = 1'b0;
    sr_we     = 1'b0;
    dm_we     = 1'b0;
    miso_buff = 1'b0;
    busy      = (state != IDLE);
    case (state)
      GOT_ADDR:     addr_we   = 1'b1;
      READ_LOAD:    sr_we     = 1'b1;
      READ_SEND:    miso_buff = 1'b1;
      WRITE_COMMIT: dm_we     = 1'b1;
      default: ;
    endcase
  end

  assign bus.addr_we   = addr_we;
  assign bus.sr_we     = sr_we;
  assign bus.dm_we     = dm_we;
  assign bus.miso_buff = miso_buff;
  assign bus.busy      = busy;
  assign dbg_state     = state;
  assign dbg_cnt       = cnt;

endmodule

// File: tb/tb_spi_fsm.sv
// Bench for spi_fsm: directed transactions plus a random run, all checked
// cycle by cycle against a timeline model of the transaction.
module tb_spi_fsm;

  logic       clk;
  logic       reset_n;
  logic [2:0] dbg_state;
  logic [3:0] dbg_cnt;

  spi_fsm_if bus ();

  spi_fsm #(.BYTE_BITS(8), .CNT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model: counts accepted address/data pulses and the clks elapsed
  // since each byte completed; strobes are fixed offsets from those moments.
  bit m_active;
  int m_a, m_d, m_ta, m_td;
  bit m_rd;

  function automatic void model_clear();
    m_active = 0; m_a = 0; m_d = 0; m_ta = -1; m_td = -1; m_rd = 0;
  endfunction

  function automatic void model_step(input logic c, input logic s, input logic r);
    int ta_o, td_o;
    if (!m_active) begin
      if (!c) begin
        model_clear();
        m_active = 1;
      end
    end else if (c) begin
      model_clear();
    end else begin
      ta_o = m_ta;
      td_o = m_td;
      if (ta_o == 1) m_rd = r;
      if (ta_o >= 0 && ta_o < 1000) m_ta = ta_o + 1;
      if (td_o >= 0 && td_o < 1000) m_td = td_o + 1;
      if (s && ta_o < 0 && m_a < 8) begin
        m_a++;
        if (m_a == 8) m_ta = 0;
      end
      if (s && ta_o >= (m_rd ? 3 : 2) && m_d < 8) begin
        m_d++;
        if (m_d == 8) m_td = 0;
      end
    end
  endfunction

  function automatic bit model_done();
    return m_active && (m_rd ? (m_td >= 1) : (m_td >= 2));
  endfunction

  int addr_seen, sr_seen, dm_seen, miso_pulses;

  task automatic check_outputs();
    logic e_addr, e_sr, e_dm, e_miso;
    e_addr = m_active && (m_ta == 1);
    e_sr   = m_active && m_rd && (m_ta == 2);
    e_miso = m_active && m_rd && (m_ta >= 3) && (m_td <= 0);
    e_dm   = m_active && !m_rd && (m_td == 1);
    check("addr_we",   32'(bus.addr_we),   32'(e_addr));
    check("sr_we",     32'(bus.sr_we),     32'(e_sr));
    check("dm_we",     32'(bus.dm_we),     32'(e_dm));
    check("miso_buff", 32'(bus.miso_buff), 32'(e_miso));
    check("busy",      32'(bus.busy),      32'(m_active));
    check("onehot",    32'($onehot0({bus.addr_we, bus.sr_we, bus.dm_we})), 32'd1);
    if (!m_active) check("idle_cnt", 32'(dbg_cnt), 32'd0);
    addr_seen += int'(bus.addr_we);
    sr_seen   += int'(bus.sr_we);
    dm_seen   += int'(bus.dm_we);
  endtask

  // driver: one clk with the given inputs, outputs checked on the negedge
  task automatic cycle(input logic c, input logic s, input logic r);
    if (bus.miso_buff && s) miso_pulses++;
    bus.cs = c; bus.sclk_pos = s; bus.rw_bit = r;
    @(posedge clk);
    model_step(c, s, r);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic pulses(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b1, r);
      cycle(1'b0, 1'b0, r);
    end
  endtask

  task automatic clear_seen();
    addr_seen = 0; sr_seen = 0; dm_seen = 0; miso_pulses = 0;
  endtask

  // complete transaction ending in DONE, cs still low
  task automatic txn(input logic r);
    cycle(1'b0, 1'b0, r);
    pulses(8, r);
    cycle(1'b0, 1'b0, r);
    cycle(1'b0, 1'b0, r);
    pulses(8, r);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, r);
  endtask

  initial begin
    model_clear();
    clear_seen();
    bus.cs = 1'b1; bus.sclk_pos = 1'b0; bus.rw_bit = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_cnt",   32'(dbg_cnt),  32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);

    // write
    clear_seen();
    txn(1'b0);
    cycle(1'b0, 1'b1, 1'b0);           // extra SCLK in DONE is ignored
    cycle(1'b1, 1'b0, 1'b0);
    check("wr_addr_cnt", 32'(addr_seen), 32'd1);
    check("wr_dm_cnt",   32'(dm_seen),   32'd1);
    check("wr_sr_cnt",   32'(sr_seen),   32'd0);
    check("wr_miso_cnt", 32'(miso_pulses), 32'd0);
    check("wr_end_busy", 32'(bus.busy), 32'd0);

    // read
    clear_seen();
    txn(1'b1);
    check("rd_done_miso", 32'(bus.miso_buff), 32'd0);
    cycle(1'b1, 1'b0, 1'b0);
    check("rd_addr_cnt", 32'(addr_seen), 32'd1);
    check("rd_sr_cnt",   32'(sr_seen),   32'd1);
    check("rd_dm_cnt",   32'(dm_seen),   32'd0);
    check("rd_miso_pls", 32'(miso_pulses), 32'd8);

    // abort after 5 data pulses
    clear_seen();
    cycle(1'b0, 1'b0, 1'b0);
    pulses(8, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    pulses(5, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("ab_busy", 32'(bus.busy), 32'd0);
    check("ab_cnt",  32'(dbg_cnt),  32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    check("ab_dm_cnt", 32'(dm_seen), 32'd0);

    // cs rises with the 8th data pulse; then SCLK while idle
    clear_seen();
    cycle(1'b0, 1'b0, 1'b0);
    pulses(8, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    pulses(7, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("co_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0);
    check("co_dm_cnt", 32'(dm_seen), 32'd0);
    check("co_idle_cnt", 32'(dbg_cnt), 32'd0);

    // two writes separated by one clk of cs high
    clear_seen();
    txn(1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    txn(1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("ww_addr_cnt", 32'(addr_seen), 32'd2);
    check("ww_dm_cnt",   32'(dm_seen),   32'd2);

    // reset mid data byte of a write
    cycle(1'b0, 1'b0, 1'b0);
    pulses(8, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    pulses(3, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("mr_busy", 32'(bus.busy), 32'd0);
    check("mr_strobes", 32'({bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff}), 32'd0);
    check("mr_cnt", 32'(dbg_cnt), 32'd0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, 1'b1, 1'b0);
    check("mr_restart", 32'(bus.busy), 32'd1);
    cycle(1'b1, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic c, s, r;
      if (!m_active)        c = ($urandom_range(0, 3) == 0);
      else if (model_done()) c = ($urandom_range(0, 2) == 0);
      else                  c = ($urandom_range(0, 99) < 2);
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      cycle(c, s, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
